// File: rtl/kbd_pkg.sv
// Shared constants, state encoding and event layout for the keyboard scancode sequencer.
package kbd_pkg;

    localparam logic [7:0] KBD_PORT_STATUS = 8'h05;
    localparam logic [7:0] KBD_PORT_DATA   = 8'h06;
    localparam logic [7:0] KBD_PORT_COMMIT = 8'h07;

    localparam logic [7:0] KBD_CODE_EXT   = 8'hE0;
    localparam logic [7:0] KBD_CODE_BRK   = 8'hF0;
    localparam logic [7:0] KBD_CODE_PAUSE = 8'hE1;

    localparam int KBD_ST_NONEMPTY  = 0;
    localparam int KBD_ST_BRK       = 1;
    localparam int KBD_ST_EXT       = 2;
    localparam int KBD_ST_OVF       = 3;
    localparam int KBD_ST_COUNT_LSB = 4;

    localparam int KBD_EVENT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } kbd_state_e;

    // Event entry layout: {brk, ext, code[7:0]}
    function automatic logic [KBD_EVENT_W-1:0] kbd_make_event(
        input logic       brk,
        input logic       ext,
        input logic [7:0] code
    );
        return {brk, ext, code};
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Circular event buffer for decoded key events; reports drops when a push meets a full buffer.
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [KBD_EVENT_W-1:0] push_data,
    input  logic                   pop,
    output logic [KBD_EVENT_W-1:0] head,
    output logic                   empty,
    output logic [3:0]             count,
    output logic                   dropped
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [3:0]       CNT_FULL = 4'(DEPTH);

    logic [KBD_EVENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [3:0]             count_r;
    logic                   full_s;
    logic                   empty_s;
    logic                   pop_ok_s;
    logic                   push_ok_s;

    // A pop frees a slot in the same cycle, so a full buffer still accepts push+pop.
    always_comb begin
        full_s    = (count_r == CNT_FULL);
        empty_s   = (count_r == 4'd0);
        pop_ok_s  = pop & ~empty_s;
        push_ok_s = push & (~full_s | pop_ok_s);
        dropped   = push & full_s & ~pop_ok_s;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/kbd_scan_sequencer.sv
// Turns the raw PS/2 scancode byte stream into key events and serves them on
// the processor's status/data/commit ports.
module kbd_scan_sequencer
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PAUSE_LEN  = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] Rx_Data,
    input  logic       Rx_Valid,
    input  logic [7:0] Port_ID,
    input  logic       Read_Strobe,
    output logic [7:0] Keyboard_Output
);

    localparam logic [7:0] PAUSE_SKIP = 8'(PAUSE_LEN - 1);

    kbd_state_e             state_r;
    kbd_state_e             state_next_s;
    logic [7:0]             skip_r;
    logic [7:0]             skip_next_s;
    logic                   push_s;
    logic [KBD_EVENT_W-1:0] push_data_s;
    logic                   strobe_prev_r;
    logic                   commit_s;
    logic                   ovf_r;
    logic                   dropped_s;
    logic [KBD_EVENT_W-1:0] head_s;
    logic                   empty_s;
    logic [3:0]             count_s;
    logic [7:0]             status_s;
    logic [7:0]             data_s;
    logic [7:0]             rd_mux_s;
    logic [7:0]             kbd_out_r;

    kbd_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .push     (push_s),
        .push_data(push_data_s),
        .pop      (commit_s),
        .head     (head_s),
        .empty    (empty_s),
        .count    (count_s),
        .dropped  (dropped_s)
    );

    // Prefix/pause sequencing; only a received byte can move the state.
    always_comb begin
        state_next_s = state_r;
        skip_next_s  = skip_r;
        push_s       = 1'b0;
        push_data_s  = {KBD_EVENT_W{1'b0}};
        if (Rx_Valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (Rx_Data == KBD_CODE_EXT) begin
                        state_next_s = ST_EXT;
                    end else if (Rx_Data == KBD_CODE_BRK) begin
                        state_next_s = ST_BRK;
                    end else if (Rx_Data == KBD_CODE_PAUSE) begin
                        if (PAUSE_SKIP == 8'd0) begin
                            push_s      = 1'b1;
                            push_data_s = kbd_make_event(1'b0, 1'b1, KBD_CODE_PAUSE);
                        end else begin
                            state_next_s = ST_PAUSE;
                            skip_next_s  = PAUSE_SKIP;
                        end
                    end else begin
                        push_s      = 1'b1;
                        push_data_s = kbd_make_event(1'b0, 1'b0, Rx_Data);
                    end
                end
                ST_EXT: begin
                    if (Rx_Data == KBD_CODE_BRK) begin
                        state_next_s = ST_EXT_BRK;
                    end else if (Rx_Data == KBD_CODE_EXT) begin
                        state_next_s = ST_EXT;
                    end else begin
                        push_s       = 1'b1;
                        push_data_s  = kbd_make_event(1'b0, 1'b1, Rx_Data);
                        state_next_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    push_s       = 1'b1;
                    push_data_s  = kbd_make_event(1'b1, 1'b0, Rx_Data);
                    state_next_s = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    push_s       = 1'b1;
                    push_data_s  = kbd_make_event(1'b1, 1'b1, Rx_Data);
                    state_next_s = ST_IDLE;
                end
                ST_PAUSE: begin
                    // Pause bytes (including embedded E1/F0) are swallowed, never decoded.
                    if (skip_r <= 8'd1) begin
                        skip_next_s  = 8'd0;
                        push_s       = 1'b1;
                        push_data_s  = kbd_make_event(1'b0, 1'b1, KBD_CODE_PAUSE);
                        state_next_s = ST_IDLE;
                    end else begin
                        skip_next_s = skip_r - 8'd1;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    skip_next_s  = 8'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Sequencer state and pause skip counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            skip_r  <= 8'd0;
        end else begin
            state_r <= state_next_s;
            skip_r  <= skip_next_s;
        end
    end

    assign commit_s = Read_Strobe & ~strobe_prev_r & (Port_ID == KBD_PORT_COMMIT);

    // Strobe history and sticky overflow; a drop cannot coincide with a successful commit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            strobe_prev_r <= 1'b0;
            ovf_r         <= 1'b0;
        end else begin
            strobe_prev_r <= Read_Strobe;
            if (dropped_s) begin
                ovf_r <= 1'b1;
            end else if (commit_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Read-port decode; head fields are masked while the buffer is empty.
    always_comb begin
        status_s = 8'h00;
        status_s[KBD_ST_NONEMPTY]              = ~empty_s;
        status_s[KBD_ST_BRK]                   = ~empty_s & head_s[9];
        status_s[KBD_ST_EXT]                   = ~empty_s & head_s[8];
        status_s[KBD_ST_OVF]                   = ovf_r;
        status_s[KBD_ST_COUNT_LSB +: 4]        = count_s;
        data_s   = empty_s ? 8'h00 : head_s[7:0];
        case (Port_ID)
            KBD_PORT_STATUS: rd_mux_s = status_s;
            KBD_PORT_DATA:   rd_mux_s = data_s;
            KBD_PORT_COMMIT: rd_mux_s = status_s;
            default:         rd_mux_s = 8'h00;
        endcase
    end

    // Registered read data; the commit edge latches the pre-pop view.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            kbd_out_r <= 8'h00;
        end else begin
            kbd_out_r <= rd_mux_s;
        end
    end

    assign Keyboard_Output = kbd_out_r;

endmodule

// File: tb/tb_kbd_scan_sequencer.sv
// Directed, table-driven bench for kbd_scan_sequencer with hand-written
// held-strobe and full-FIFO push+commit sequences.
module tb_kbd_scan_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] Rx_Data;
    logic       Rx_Valid;
    logic [7:0] Port_ID;
    logic       Read_Strobe;
    logic [7:0] Keyboard_Output;

    int tests_run = 0;
    int tests_failed = 0;

    kbd_scan_sequencer #(
        .FIFO_DEPTH(4),
        .PAUSE_LEN (8)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Rx_Data        (Rx_Data),
        .Rx_Valid       (Rx_Valid),
        .Port_ID        (Port_ID),
        .Read_Strobe    (Read_Strobe),
        .Keyboard_Output(Keyboard_Output)
    );

    always #5 CLK = ~CLK;

    localparam logic [2:0] OP_RX  = 3'd0;  // one Rx_Valid pulse, no check
    localparam logic [2:0] OP_RD  = 3'd1;  // read port arg, expect exp
    localparam logic [2:0] OP_CM  = 3'd2;  // commit edge on 0x07, expect exp (pre-pop)
    localparam logic [2:0] OP_RST = 3'd3;  // one reset cycle, expect 0x00

    typedef struct {
        logic [2:0] op;
        logic [7:0] arg;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] op, input logic [7:0] arg, input logic [7:0] exp);
        vec_t v;
        v.op  = op;
        v.arg = arg;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        tests_run++;
        if (Keyboard_Output !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, Keyboard_Output, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        string name;
        name = $sformatf("vec%0d", idx);
        case (v.op)
            OP_RX: begin
                Rx_Data  = v.arg;
                Rx_Valid = 1'b1;
                tick();
                Rx_Valid = 1'b0;
            end
            OP_RD: begin
                Port_ID = v.arg;
                tick();
                check({name, "_read"}, v.exp);
            end
            OP_CM: begin
                Port_ID     = 8'h07;
                Read_Strobe = 1'b1;
                tick();
                check({name, "_commit"}, v.exp);
                Read_Strobe = 1'b0;
                tick();
            end
            default: begin
                RESET = 1'b1;
                tick();
                check({name, "_reset"}, 8'h00);
                RESET = 1'b0;
            end
        endcase
    endtask

    initial begin
        RESET       = 1'b1;
        Rx_Data     = 8'h00;
        Rx_Valid    = 1'b0;
        Port_ID     = 8'h00;
        Read_Strobe = 1'b0;

        // Reset state
        add(OP_RST, 8'h00, 8'h00);
        add(OP_RD,  8'h05, 8'h00);
        add(OP_RD,  8'h06, 8'h00);
        // Plain make (F11), plus commit-port read without strobe and unmapped ports
        add(OP_RX,  8'h78, 8'h00);
        add(OP_RD,  8'h05, 8'h11);
        add(OP_RD,  8'h06, 8'h78);
        add(OP_RD,  8'h07, 8'h11);
        add(OP_RD,  8'h08, 8'h00);
        add(OP_RD,  8'h04, 8'h00);
        add(OP_CM,  8'h07, 8'h11);
        add(OP_RD,  8'h05, 8'h00);
        // Extended break
        add(OP_RX,  8'hE0, 8'h00);
        add(OP_RX,  8'hF0, 8'h00);
        add(OP_RX,  8'h75, 8'h00);
        add(OP_RD,  8'h05, 8'h17);
        add(OP_RD,  8'h06, 8'h75);
        add(OP_CM,  8'h07, 8'h17);
        add(OP_RD,  8'h05, 8'h00);
        // Plain break
        add(OP_RX,  8'hF0, 8'h00);
        add(OP_RD,  8'h05, 8'h00);
        add(OP_RX,  8'h1C, 8'h00);
        add(OP_RD,  8'h05, 8'h13);
        add(OP_CM,  8'h07, 8'h13);
        // Pause: no event until the eighth byte
        add(OP_RX,  8'hE1, 8'h00);
        add(OP_RD,  8'h05, 8'h00);
        add(OP_RX,  8'h14, 8'h00);
        add(OP_RX,  8'h77, 8'h00);
        add(OP_RX,  8'hE1, 8'h00);
        add(OP_RD,  8'h05, 8'h00);
        add(OP_RX,  8'hF0, 8'h00);
        add(OP_RX,  8'h14, 8'h00);
        add(OP_RX,  8'hF0, 8'h00);
        add(OP_RD,  8'h05, 8'h00);
        add(OP_RX,  8'h77, 8'h00);
        add(OP_RD,  8'h05, 8'h15);
        add(OP_RD,  8'h06, 8'hE1);
        add(OP_CM,  8'h07, 8'h15);
        add(OP_RD,  8'h05, 8'h00);
        // Overflow: fifth make dropped
        add(OP_RX,  8'h1C, 8'h00);
        add(OP_RX,  8'h1B, 8'h00);
        add(OP_RX,  8'h23, 8'h00);
        add(OP_RX,  8'h2B, 8'h00);
        add(OP_RX,  8'h34, 8'h00);
        add(OP_RD,  8'h05, 8'h49);
        add(OP_RD,  8'h06, 8'h1C);
        add(OP_CM,  8'h07, 8'h49);
        add(OP_RD,  8'h05, 8'h31);
        add(OP_RD,  8'h06, 8'h1B);
        add(OP_CM,  8'h07, 8'h31);
        add(OP_CM,  8'h07, 8'h21);
        add(OP_RD,  8'h06, 8'h2B);
        add(OP_CM,  8'h07, 8'h11);
        add(OP_RD,  8'h05, 8'h00);
        add(OP_CM,  8'h07, 8'h00);
        add(OP_RD,  8'h05, 8'h00);
        // Reset mid-sequence discards the E0 prefix
        add(OP_RX,  8'hE0, 8'h00);
        add(OP_RST, 8'h00, 8'h00);
        add(OP_RX,  8'h1C, 8'h00);
        add(OP_RD,  8'h05, 8'h11);
        add(OP_RD,  8'h06, 8'h1C);
        add(OP_CM,  8'h07, 8'h11);
        // Reset empties a non-empty buffer
        add(OP_RX,  8'h2B, 8'h00);
        add(OP_RST, 8'h00, 8'h00);
        add(OP_RD,  8'h05, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Held strobe: three cycles high on 0x07 pops exactly once
        Rx_Data = 8'h1C; Rx_Valid = 1'b1; tick();
        Rx_Data = 8'h1B; tick();
        Rx_Valid = 1'b0;
        Port_ID = 8'h07; Read_Strobe = 1'b1;
        tick(); check("held_cyc1", 8'h21);
        tick(); check("held_cyc2", 8'h11);
        tick(); check("held_cyc3", 8'h11);
        Read_Strobe = 1'b0; Port_ID = 8'h05;
        tick(); check("held_status", 8'h11);
        Port_ID = 8'h06;
        tick(); check("held_data", 8'h1B);
        Port_ID = 8'h07; Read_Strobe = 1'b1;
        tick(); check("held_drain", 8'h11);
        Read_Strobe = 1'b0; Port_ID = 8'h05;
        tick(); check("held_empty", 8'h00);

        // Full FIFO: push and commit in the same cycle keep count 4, no overflow
        for (int i = 0; i < 4; i++) begin
            Rx_Data  = 8'h10 + 8'(i);
            Rx_Valid = 1'b1;
            tick();
        end
        Rx_Valid = 1'b0;
        tick(); check("sim_full", 8'h41);
        Rx_Data = 8'h34; Rx_Valid = 1'b1;
        Port_ID = 8'h07; Read_Strobe = 1'b1;
        tick(); check("sim_commit", 8'h41);
        Rx_Valid = 1'b0; Read_Strobe = 1'b0; Port_ID = 8'h05;
        tick(); check("sim_status", 8'h41);
        Port_ID = 8'h06;
        tick(); check("sim_head", 8'h11);
        for (int i = 0; i < 3; i++) begin
            Port_ID = 8'h07; Read_Strobe = 1'b1;
            tick(); check($sformatf("sim_drain%0d", i), 8'(8'h41 - 8'(i * 16)));
            Read_Strobe = 1'b0;
            tick();
        end
        Port_ID = 8'h06;
        tick(); check("sim_tail", 8'h34);
        Port_ID = 8'h05;
        tick(); check("sim_last", 8'h11);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
